// File: rtl/plic_pkg.sv
// Shared PLIC register offsets and ID type.
package plic_pkg;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned ID_W   = 5;

  localparam logic [ADDR_W-1:0] PRIO_BASE = 22'h000000;
  localparam logic [ADDR_W-1:0] PEND_OFF  = 22'h001000;
  localparam logic [ADDR_W-1:0] EN_OFF    = 22'h002000;
  localparam logic [ADDR_W-1:0] THR_OFF   = 22'h200000;
  localparam logic [ADDR_W-1:0] CLAIM_OFF = 22'h200004;

  typedef logic [ID_W-1:0] id_t;
endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: optional 2-flop synchroniser, level/edge trigger, pending/in_flight state.
module plic_gateway #(
  parameter bit SYNC_EN = 1'b1,
  parameter bit EDGE    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_flight
);
  logic src_s;
  logic src_d;
  logic trig_c;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], src};
      end
      assign src_s = sync_q[1];
    end else begin : g_nosync
      assign src_s = src;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_d <= 1'b0;
    else        src_d <= src_s;
  end

  assign trig_c = EDGE ? (src_s & ~src_d) : src_s;

  // A claim beats a simultaneous trigger; triggers are ignored while pending or in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      if (claim)                                pending <= 1'b0;
      else if (trig_c && !pending && !in_flight) pending <= 1'b1;
      if (claim)         in_flight <= 1'b1;
      else if (complete) in_flight <= 1'b0;
    end
  end
endmodule

// File: rtl/plic_core.sv
// Platform-level interrupt controller: gateways, priority arbiter, claim/complete register file.
module plic_core
  import plic_pkg::*;
#(
  parameter int unsigned          NUM_SRC   = 8,
  parameter int unsigned          PRIO_W    = 3,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = '0,
  parameter bit                   SYNC_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               req,
  input  logic               we,
  input  logic [21:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ack,
  output logic               irq_ext
);
  localparam int unsigned IDX_W = 10;

  logic [NUM_SRC:1]  pending;
  logic [NUM_SRC:1]  in_flight;
  logic [NUM_SRC:1]  claim_vec;
  logic [NUM_SRC:1]  complete_vec;
  logic [NUM_SRC:1]  en_q;
  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0] thr_q;
  id_t               best_id_q;
  id_t               best_id_c;
  logic [PRIO_W-1:0] best_prio_c;
  logic [IDX_W-1:0]  prio_idx_c;
  logic              prio_sel_c;
  logic              claim_c;
  logic              compl_c;
  logic [31:0]       rdata_c;
  logic              unused_bits;

  assign unused_bits = ^{wdata, in_flight};

  assign prio_idx_c = addr[11:2];
  assign prio_sel_c = (addr[21:12] == PRIO_BASE[21:12]) && (addr[1:0] == 2'b00);
  assign claim_c    = req && !we && (addr == CLAIM_OFF) && (best_id_q != '0);
  assign compl_c    = req &&  we && (addr == CLAIM_OFF);

  // Decode claim/complete per source; out-of-range or disabled IDs match nothing.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      claim_vec[i]    = claim_c && (best_id_q == ID_W'(i));
      complete_vec[i] = compl_c && (wdata[ID_W-1:0] == ID_W'(i)) && en_q[i];
    end
  end

  generate
    for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
      plic_gateway #(
        .SYNC_EN (SYNC_EN),
        .EDGE    (EDGE_MASK[g-1])
      ) u_gw (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src[g-1]),
        .claim     (claim_vec[g]),
        .complete  (complete_vec[g]),
        .pending   (pending[g]),
        .in_flight (in_flight[g])
      );
    end
  endgenerate

  // Highest priority wins; ascending scan with strict compare keeps the lowest ID on ties.
  always_comb begin
    best_id_c   = '0;
    best_prio_c = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pending[i] && en_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > best_prio_c)) begin
        best_prio_c = prio_q[i];
        best_id_c   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_id_q <= '0;
      irq_ext   <= 1'b0;
    end else begin
      best_id_q <= best_id_c;
      irq_ext   <= (best_id_c != '0);
    end
  end

  always_comb begin
    rdata_c = '0;
    if (prio_sel_c) begin
      for (int i = 1; i <= NUM_SRC; i++)
        if (prio_idx_c == IDX_W'(i)) rdata_c = 32'(prio_q[i]);
    end else if (addr == PEND_OFF) begin
      rdata_c = 32'({pending, 1'b0});
    end else if (addr == EN_OFF) begin
      rdata_c = 32'({en_q, 1'b0});
    end else if (addr == THR_OFF) begin
      rdata_c = 32'(thr_q);
    end else if (addr == CLAIM_OFF) begin
      rdata_c = 32'(best_id_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= (req && !we) ? rdata_c : '0;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= '0;
      thr_q <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
    end else if (req && we) begin
      if (prio_sel_c) begin
        for (int i = 1; i <= NUM_SRC; i++)
          if (prio_idx_c == IDX_W'(i)) prio_q[i] <= wdata[PRIO_W-1:0];
      end
      if (addr == EN_OFF)  en_q  <= wdata[NUM_SRC:1];
      if (addr == THR_OFF) thr_q <= wdata[PRIO_W-1:0];
    end
  end
endmodule

// File: tb/tb_plic_core.sv
// Scoreboard bench for plic_core: directed register accesses, irq_ext timing checks.
module tb_plic_core;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src;
  logic        req;
  logic        we;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        irq_ext;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q  [$];
  bit          chk_q  [$];
  string       name_q [$];

  localparam logic [21:0] A_PEND  = 22'h001000;
  localparam logic [21:0] A_EN    = 22'h002000;
  localparam logic [21:0] A_THR   = 22'h200000;
  localparam logic [21:0] A_CLAIM = 22'h200004;

  plic_core #(
    .NUM_SRC   (8),
    .PRIO_W    (3),
    .EDGE_MASK (8'h01),
    .SYNC_EN   (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .irq_ext (irq_ext)
  );

  always #5 clk = ~clk;

  // Monitor: every ack pops one scoreboard entry; reads are compared.
  initial begin
    forever begin
      @(negedge clk);
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: ack=1 with no outstanding request");
        end else begin
          logic [31:0] e;
          bit          c;
          string       n;
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          n = name_q.pop_front();
          if (c) begin
            checks++;
            if (rdata !== e) begin
              errors++;
              $display("FAIL %s: rdata=0x%08h expected=0x%08h", n, rdata, e);
            end
          end
        end
      end
    end
  end

  // Caller is at a negedge; request is sampled at the following posedge.
  task automatic acc(input bit w, input logic [21:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string n);
    we = w; addr = a; wdata = d; req = 1'b1;
    exp_q.push_back(e);
    chk_q.push_back(!w);
    name_q.push_back(n);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [21:0] a, input logic [31:0] e, input string n);
    acc(1'b0, a, 32'h0, e, n);
  endtask

  task automatic wr(input logic [21:0] a, input logic [31:0] d);
    acc(1'b1, a, d, 32'h0, "write");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_irq(input logic e, input string n);
    checks++;
    if (irq_ext !== e) begin
      errors++;
      $display("FAIL %s: irq_ext=%b expected=%b", n, irq_ext, e);
    end
  endtask

  task automatic wait_irq(input logic e, input int max, input string n);
    for (int i = 0; i < max; i++) begin
      if (irq_ext === e) break;
      @(negedge clk);
    end
    check_irq(e, n);
  endtask

  initial begin
    rst_n = 1'b0; src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    idle(3);
    check_irq(1'b0, "reset_irq");
    rst_n = 1'b1;
    idle(2);

    // 1: reset values
    rd(22'h00000C, 32'h0, "reset_prio3");
    rd(A_PEND,     32'h0, "reset_pending");
    rd(A_EN,       32'h0, "reset_enable");
    rd(A_THR,      32'h0, "reset_thr");
    rd(A_CLAIM,    32'h0, "reset_claim");
    rd(22'h000100, 32'h0, "unmapped_prio64");
    rd(22'h000000, 32'h0, "prio0_zero");

    // 2: level source 3
    wr(22'h00000C, 32'd2);
    wr(A_EN, 32'h08);
    wr(A_THR, 32'd1);
    rd(22'h00000C, 32'd2, "prio3_rb");
    wr(A_EN, 32'hFFFF_FFFF);
    rd(A_EN, 32'h0000_01FE, "enable_mask");
    wr(A_EN, 32'h08);
    src[2] = 1'b1;
    wait_irq(1'b1, 4, "lvl3_irq");
    rd(A_PEND,  32'h08, "lvl3_pending");
    rd(A_CLAIM, 32'd3,  "lvl3_claim");
    idle(1);
    check_irq(1'b0, "lvl3_irq_after_claim");
    rd(A_PEND, 32'h0, "lvl3_pending_cleared");
    wr(A_CLAIM, 32'd3);
    wait_irq(1'b1, 6, "lvl3_repend_irq");
    rd(A_CLAIM, 32'd3, "lvl3_claim2");
    src[2] = 1'b0;
    idle(4);
    wr(A_CLAIM, 32'd3);
    idle(4);
    rd(A_PEND, 32'h0, "lvl3_idle");

    // 3: priority order and ID tiebreak
    wr(22'h000008, 32'd5);
    wr(22'h000014, 32'd5);
    wr(22'h000018, 32'd7);
    wr(A_EN, 32'h6C);
    src[1] = 1'b1; src[4] = 1'b1; src[5] = 1'b1;
    idle(6);
    rd(A_PEND,  32'h64, "arb_pending");
    rd(A_CLAIM, 32'd6,  "arb_claim6");
    idle(2);
    rd(A_CLAIM, 32'd2,  "arb_claim2");
    idle(2);
    rd(A_CLAIM, 32'd5,  "arb_claim5");
    idle(2);
    rd(A_CLAIM, 32'd0,  "arb_claim_none");
    src[1] = 1'b0; src[4] = 1'b0; src[5] = 1'b0;
    idle(4);
    wr(A_CLAIM, 32'd6);
    wr(A_CLAIM, 32'd2);
    wr(A_CLAIM, 32'd5);

    // 4: threshold boundary
    wr(22'h000018, 32'd5);
    wr(A_EN, 32'h40);
    wr(A_THR, 32'd5);
    src[5] = 1'b1;
    idle(6);
    check_irq(1'b0, "thr_equal_blocks");
    rd(A_PEND, 32'h40, "thr_pending");
    wr(A_THR, 32'd4);
    check_irq(1'b0, "thr_old_value");
    idle(1);
    check_irq(1'b1, "thr_lowered");
    rd(A_CLAIM, 32'd6, "thr_claim6");
    src[5] = 1'b0;
    idle(4);
    wr(A_CLAIM, 32'd6);
    wr(A_THR, 32'd0);

    // 5: edge source 1
    wr(22'h000004, 32'd1);
    wr(A_EN, 32'h02);
    for (int k = 0; k < 3; k++) begin
      src[0] = 1'b1; idle(1);
      src[0] = 1'b0; idle(2);
    end
    idle(3);
    rd(A_PEND,  32'h02, "edge_pending");
    rd(A_CLAIM, 32'd1,  "edge_claim1");
    idle(2);
    rd(A_CLAIM, 32'd0,  "edge_claim_once");
    wr(A_CLAIM, 32'd1);
    src[0] = 1'b1; idle(1);
    src[0] = 1'b0; idle(6);
    src[0] = 1'b1; idle(1);
    src[0] = 1'b0; idle(1);
    rd(A_CLAIM, 32'd1, "edge_claim_coincident");
    idle(1);
    wr(A_CLAIM, 32'd1);
    idle(6);
    rd(A_PEND, 32'h0, "edge_dropped_pending");
    check_irq(1'b0, "edge_dropped_irq");

    // 6: async reset during a claim
    wr(22'h00000C, 32'd2);
    wr(A_EN, 32'h08);
    src[2] = 1'b1;
    wait_irq(1'b1, 6, "rst_setup_irq");
    we = 1'b0; addr = A_CLAIM; req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_irq(1'b0, "async_rst_irq");
    checks++;
    if (ack !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_rst_bus: ack=%b rdata=0x%08h expected ack=0 rdata=0", ack, rdata);
    end
    req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd(A_EN,       32'h0, "post_rst_enable");
    rd(22'h00000C, 32'h0, "post_rst_prio3");
    wr(22'h00000C, 32'd2);
    wr(A_EN, 32'h08);
    wait_irq(1'b1, 6, "post_rst_irq");
    rd(A_CLAIM, 32'd3, "post_rst_claim");
    wr(A_CLAIM, 32'd0);
    wr(A_CLAIM, 32'd9);
    wr(A_EN, 32'h00);
    wr(A_CLAIM, 32'd3);
    wr(A_EN, 32'h08);
    idle(6);
    check_irq(1'b0, "bad_complete_ignored");
    rd(A_PEND, 32'h0, "bad_complete_pending");
    wr(A_CLAIM, 32'd3);
    wait_irq(1'b1, 6, "good_complete_irq");

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ack_drain: outstanding=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
